// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM sequencer: walks every radix-2 DIT stage/butterfly, issues one ROM read per
// butterfly and streams the tagged (optionally conjugated) twiddle over valid/ready.
module twiddle_addr_gen #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 18,
  localparam int LOG2N = ADDR_WIDTH + 1,
  localparam int SW = $clog2(LOG2N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inverse,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_real,
  input  logic [DATA_WIDTH-1:0] rom_imag,
  output logic                  tw_valid,
  input  logic                  tw_ready,
  output logic [DATA_WIDTH-1:0] tw_real,
  output logic [DATA_WIDTH-1:0] tw_imag,
  output logic [SW-1:0]         tw_stage,
  output logic [ADDR_WIDTH-1:0] tw_bfly
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           s_cnt;
  logic [ADDR_WIDTH-1:0]   j_cnt;
  logic                    inv_q;
  logic                    issue;
  logic                    last_rd;
  logic [SW-1:0]           shamt;
  logic [ADDR_WIDTH-1:0]   mask;
  logic [ADDR_WIDTH-1:0]   addr_calc;
  logic signed [DATA_WIDTH-1:0] imag_s;

  function automatic logic signed [DATA_WIDTH-1:0] sat_neg(
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [DATA_WIDTH-1:0] min_val;
    min_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (x == min_val) sat_neg = ~min_val;
    else              sat_neg = -x;
  endfunction

  assign issue   = (state == RUN) && (!tw_valid || tw_ready);
  assign last_rd = (s_cnt == SW'(LOG2N - 1)) && (&j_cnt);

  // Stage s uses 2^s distinct twiddles spread evenly over the ROM depth.
  assign shamt     = SW'(ADDR_WIDTH) - s_cnt;
  assign mask      = {ADDR_WIDTH{1'b1}} >> shamt;
  assign addr_calc = (j_cnt & mask) << shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && last_rd) state_nxt = DRAIN;
      DRAIN:   if (tw_valid && tw_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    rom_rd_en = issue;
    rom_addr  = (state == RUN) ? addr_calc : '0;
  end

  // Stage p0: issue counters; the stage counter steps each time the butterfly index wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_cnt <= '0;
      j_cnt <= '0;
      inv_q <= 1'b0;
    end else if (state == IDLE && start) begin
      s_cnt <= '0;
      j_cnt <= '0;
      inv_q <= inverse;
    end else if (issue) begin
      j_cnt <= j_cnt + 1'b1;
      if (&j_cnt) s_cnt <= last_rd ? '0 : s_cnt + 1'b1;
    end
  end

  // Stage p1: ROM data arrives; valid and tags line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_bfly  <= '0;
    end else if (issue) begin
      tw_valid <= 1'b1;
      tw_stage <= s_cnt;
      tw_bfly  <= j_cnt;
    end else if (tw_valid && tw_ready) begin
      tw_valid <= 1'b0;
    end
  end

  assign imag_s  = $signed(rom_imag);
  assign tw_real = rom_real;
  assign tw_imag = inv_q ? sat_neg(imag_s) : imag_s;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen: driver pushes expected words per sequence,
// negedge monitor pops and compares every ROM read and every accepted twiddle.
module tb_twiddle_addr_gen;
  localparam int AW    = 9;
  localparam int DW    = 18;
  localparam int LOG2N = AW + 1;
  localparam int NB    = 1 << AW;
  localparam int TOTAL = LOG2N * NB;

  logic clk;
  logic rst, start, inverse, tw_ready;
  logic busy, done, rom_rd_en, tw_valid;
  logic [AW-1:0] rom_addr, tw_bfly;
  logic [DW-1:0] rom_real, rom_imag, tw_real, tw_imag;
  logic [3:0]    tw_stage;

  twiddle_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
    .rom_real(rom_real), .rom_imag(rom_imag), .tw_valid(tw_valid),
    .tw_ready(tw_ready), .tw_real(tw_real), .tw_imag(tw_imag),
    .tw_stage(tw_stage), .tw_bfly(tw_bfly)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int stage;
    int bfly;
    int re;
    int im;
  } exp_t;

  exp_t q[$];
  int   aq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   imag_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rom_re_val(input int a);
    return a;
  endfunction

  function automatic int rom_im_val(input int a);
    if (imag_mode != 0 && a == 0) return 1 << (DW - 1);
    if (imag_mode == 2) return (a * 7919 + 12345) % (1 << DW);
    return a + 1;
  endfunction

  // Two's-complement negation of a DW-bit word, clamped to the positive maximum.
  function automatic int ref_neg(input int raw);
    int v;
    v = raw;
    if (v >= (1 << (DW - 1))) v -= (1 << DW);
    v = -v;
    if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
    if (v < 0) v += (1 << DW);
    return v;
  endfunction

  task automatic build_expected(input bit inv);
    int   a;
    exp_t e;
    q.delete();
    aq.delete();
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < NB; j++) begin
        a = (j % (1 << s)) * (1 << (AW - s));
        aq.push_back(a);
        e.stage = s;
        e.bfly  = j;
        e.re    = rom_re_val(a);
        e.im    = inv ? ref_neg(rom_im_val(a)) : rom_im_val(a);
        q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rom_rd_en) begin
      rom_real <= DW'(rom_re_val(int'(rom_addr)));
      rom_imag <= DW'(rom_im_val(int'(rom_addr)));
    end
  end

  bit            prev_stall = 0;
  logic [DW-1:0] h_re, h_im;
  logic [3:0]    h_st;
  logic [AW-1:0] h_bf;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (rom_rd_en) begin
        if (aq.size() == 0) check("rd_extra", 1, 0);
        else begin
          a = aq.pop_front();
          check("rom_addr", rom_addr, a);
        end
      end
      if (prev_stall && tw_valid) begin
        check("hold_real", tw_real, h_re);
        check("hold_imag", tw_imag, h_im);
        check("hold_stage", tw_stage, h_st);
        check("hold_bfly", tw_bfly, h_bf);
      end
      if (tw_valid && !tw_ready) check("rd_during_stall", rom_rd_en, 0);
      if (tw_valid && tw_ready) begin
        if (q.size() == 0) check("word_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("tw_stage", tw_stage, e.stage);
          check("tw_bfly", tw_bfly, e.bfly);
          check("tw_real", tw_real, e.re);
          check("tw_imag", tw_imag, e.im);
        end
        acc_cnt++;
      end
      if (done) check("done_with_valid", tw_valid, 0);
      prev_stall = tw_valid && !tw_ready;
      h_re = tw_real;
      h_im = tw_imag;
      h_st = tw_stage;
      h_bf = tw_bfly;
    end
  end

  // mode 0: ready held high, 1: 3-cycle drop at word 700, 2: random ready, 3: stray start at cycle 50
  task automatic run_seq(input bit inv, input int mode);
    int k, done_cyc, stalls, hold, exp_done;
    build_expected(inv);
    acc_cnt  = 0;
    done_cyc = -1;
    stalls   = 0;
    hold     = 0;
    @(posedge clk); #1;
    start = 1'b1; inverse = inv; tw_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; inverse = 1'b0;
    k = 1;
    while (k < 20000) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_c1", busy, 1);
        check("rd_en_c1", rom_rd_en, 1);
        check("valid_c1", tw_valid, 0);
      end
      if (k == 2) check("valid_c2", tw_valid, 1);
      if (tw_valid && !tw_ready) stalls++;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
      k++;
      case (mode)
        1: begin
          tw_ready = !(tw_valid && acc_cnt == 700 && hold < 3);
          if (!tw_ready) hold++;
        end
        2: tw_ready = ($urandom % 3) != 0;
        default: tw_ready = 1'b1;
      endcase
      start   = (mode == 3 && k == 50);
      inverse = start;
    end
    tw_ready = 1'b1;
    if (done_cyc < 0) check("done_timeout", 1, 0);
    exp_done = (mode == 1) ? 5125 : (mode == 2) ? 5122 + stalls : 5122;
    check("done_cycle", done_cyc, exp_done);
    check("word_count", acc_cnt, TOTAL);
    check("words_left", q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_fall", busy, 0);
    check("valid_after", tw_valid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rom_rd_en, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_valid"}, tw_valid, 0);
    check({tag, "_stage"}, tw_stage, 0);
    check({tag, "_bfly"}, tw_bfly, 0);
  endtask

  task automatic run_reset_mid();
    int k;
    bit saw_done;
    imag_mode = 0;
    build_expected(0);
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; inverse = 1'b0; tw_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    saw_done = 0;
    while (k < 1010) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (k == 999) check("busy_before_rst", busy, 1);
      if (k == 1002) check_idle_outputs("mid_rst");
      @(posedge clk); #1;
      k++;
      rst = (k == 1000 || k == 1001);
      if (k == 1002) begin
        q.delete();
        aq.delete();
      end
    end
    check("no_done_after_rst", saw_done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0; tw_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    imag_mode = 0; run_seq(1'b0, 0);
    imag_mode = 0; run_seq(1'b0, 1);
    imag_mode = 1; run_seq(1'b1, 0);
    imag_mode = 0; run_seq(1'b0, 3);
    run_reset_mid();
    imag_mode = 0; run_seq(1'b0, 0);
    imag_mode = 2; run_seq(1'($urandom % 2), 2);
    imag_mode = 2; run_seq(1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/twiddle_addr_gen.md
# twiddle_addr_gen

Sequencer on the requesting side of the twiddle ROM. It walks every radix-2 DIT stage and butterfly of an N = 2^(ADDR_WIDTH+1)-point FFT and issues one ROM read per butterfly. It pairs the returned real/imag words with stage and butterfly tags, optionally conjugates them for inverse transforms, and delivers them to the butterfly datapath over a valid/ready stream.

## Interface
- ADDR_WIDTH, default 9: ROM address width. ROM depth and butterflies per stage are both 2^ADDR_WIDTH. Number of stages is LOG2N = ADDR_WIDTH+1.
- DATA_WIDTH, default 18: width of each twiddle component, signed two's complement.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins one full sequence when sampled high in IDLE.
- inverse  in  1  sampled with start; 1 selects conjugated twiddles.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final twiddle is accepted.
- rom_rd_en  out  1  ROM read enable.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_real  in  DATA_WIDTH  ROM real output; valid 1 cycle after rom_rd_en; held while rom_rd_en is low.
- rom_imag  in  DATA_WIDTH  ROM imag output; same timing as rom_real.
- tw_valid  out  1  twiddle output valid.
- tw_ready  in  1  consumer accepts the word when tw_valid && tw_ready.
- tw_real  out  DATA_WIDTH  equals rom_real.
- tw_imag  out  DATA_WIDTH  rom_imag, or its saturated negation when inverse is latched.
- tw_stage  out  $clog2(LOG2N)  stage tag of the current word.
- tw_bfly  out  ADDR_WIDTH  butterfly index tag of the current word.

## Operation
- States:
  - IDLE -> RUN when start = 1. Latch inverse and clear counters s = 0, j = 0.
  - RUN -> DRAIN on the cycle the last read issues (s = LOG2N-1, j = 2^ADDR_WIDTH-1).
  - DRAIN -> DONE when the final word is accepted.
  - DONE -> IDLE unconditionally.
- start is ignored outside IDLE. inverse is ignored except on the start cycle.
- Issue rule: in RUN, rom_rd_en = !tw_valid || tw_ready. rom_rd_en is 0 in all other states.
- Address: rom_addr = (j & (2^s - 1)) << (ADDR_WIDTH - s). Stage 0 always reads address 0. Stage LOG2N-1 reads address j.
- Counter advance on each issue:
  - j increments.
  - When j wraps from 2^ADDR_WIDTH-1 to 0, s increments.
- tw_valid register:
  - Set to 1 on the cycle after an issue.
  - Cleared when the word is accepted and no new issue occurs in the same cycle.
- Tag registers: tw_stage and tw_bfly load the issuing s and j on the same edge that sets tw_valid.
- Backpressure: while tw_valid && !tw_ready there is no issue. The ROM therefore holds its output, and tw_real, tw_imag and the tags remain stable.
- Inverse negation: tw_imag = -rom_imag. The most-negative value -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
- Total words per sequence: LOG2N * 2^ADDR_WIDTH. The default is 10 * 512 = 5120.
- Reset, including mid-sequence:
  - State returns to IDLE; counters and tags clear.
  - busy, done, rom_rd_en, rom_addr and tw_valid are all 0.
  - tw_stage and tw_bfly are 0.
  - The latched inverse flag is 0.
  - Any in-flight word is discarded with no done pulse.

## Timing
- start is sampled high at edge 0. busy and rom_rd_en are high in cycle 1. The first tw_valid appears in cycle 2. Read latency is 1 cycle and throughput is 1 word/cycle when tw_ready = 1.
- With tw_ready held at 1 (default parameters):
  - Reads issue in cycles 1..5120.
  - tw_valid is high in cycles 2..5121.
  - done is high in cycle 5122.
  - busy falls in cycle 5123.
- Each low cycle of tw_ready on a valid word adds exactly one cycle to the sequence.
- done is never asserted together with tw_valid.

## Test plan
- Reset: assert rst for 2 cycles at any point -> every output is 0 in the cycle after reset, state is IDLE, and no rom_rd_en.
- Full forward run, tw_ready = 1, rom model returns real = addr, imag = addr + 1 -> exactly 5120 words.
  - Stage 0 words: all addr 0.
  - Stage 1 words: addresses alternate 0, 256.
  - Stage 9 words: addresses 0..511.
  - Tags match (s, j) for every word.
  - done in cycle 5122.
- Backpressure: drop tw_ready for 3 cycles at word 700 -> word 700 is held stable with no rom_rd_en during the hold, no word is lost or duplicated, and done arrives in cycle 5125.
- Inverse: start with inverse = 1, rom_imag = 0x00005 -> tw_imag = 0x3FFFB. rom_imag = 0x20000 -> tw_imag = 0x1FFFF.
- start asserted in cycle 50 during a run -> ignored; the sequence count and done timing are unchanged.
- rst asserted in cycle 1000 mid-run -> no done pulse; a new start afterwards produces a clean 5120-word sequence beginning at stage 0, butterfly 0.
